// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared definitions for the data memory controller and its RAM bank:
// the access size encodings, the FSM state enum, the per-request response
// bookkeeping record, and the byte-enable helper used on the store path.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PROG  = 2'd2
    } state_t;

    // Everything the response stage needs to know about an accepted request
    // so that lane select and extension can be applied when the data arrives.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] lo;
    } rsp_meta_t;

    // Byte-lane enables for a store of the given size at byte offset lo.
    // Misaligned cases are filtered out by the controller before this is used.
    function automatic logic [3:0] byteEnables(input logic [1:0] size,
                                               input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_bank_be.sv
// mem_bank_be
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a
// synchronous (registered) read port. Contents have no reset.
// Ports:
//   i_clk   - clock, rising edge
//   i_en    - access enable; when low the read register holds its value
//   i_be    - byte-lane write enables (all zero = pure read)
//   i_addr  - word index
//   i_wdata - write data, already placed on the target lanes
//   o_rdata - word read on the previous enabled edge
module mem_bank_be #(
    parameter  int DEPTH_WORDS = 16384,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Read returns the pre-write contents; stores never use the read data,
    // and a load on the following cycle sees the committed bytes.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// CPU data memory controller: a valid/ready request port with byte, half
// and word loads/stores, error reporting for misaligned, oversized and
// illegal-size accesses, a fixed RD_LAT response pipeline, and a
// drain-safe programming mode through which the UART loader writes words.
// Ports:
//   i_clk, i_rst                  - clock and asynchronous active-high reset
//   i_req_* / o_req_ready         - CPU request channel
//   o_rsp_valid/_rdata/_err       - in-order responses, RD_LAT after acceptance
//   i_prog_start/_wen/_addr/_wdata/_done - programming interface
//   o_cpu_mode                    - 1 while the CPU owns the memory
//   o_prog_cnt                    - words written since the last prog_start
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 16384,
    parameter  int RD_LAT      = 1,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [1:0]       i_req_size,
    input  logic             i_req_unsigned,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    output logic             o_rsp_valid,
    output logic [31:0]      o_rsp_rdata,
    output logic             o_rsp_err,
    input  logic             i_prog_start,
    input  logic             i_prog_wen,
    input  logic [IDX_W-1:0] i_prog_addr,
    input  logic [31:0]      i_prog_wdata,
    input  logic             i_prog_done,
    output logic             o_cpu_mode,
    output logic [15:0]      o_prog_cnt
);

    state_t      r_state;
    logic        r_reqReady;
    logic        r_cpuMode;
    logic [15:0] r_progCnt;
    rsp_meta_t   r_meta [RD_LAT];

    logic             w_accept;
    logic             w_reqErr;
    logic [3:0]       w_cpuBe;
    logic [31:0]      w_storeData;
    logic             w_ramEn;
    logic [3:0]       w_ramBe;
    logic [IDX_W-1:0] w_ramAddr;
    logic [31:0]      w_ramWdata;
    logic [31:0]      w_ramRdata;
    logic [31:0]      w_outData;
    logic             w_drainDone;
    rsp_meta_t        w_newMeta;
    rsp_meta_t        w_out;
    logic [7:0]       w_lane8;
    logic [15:0]      w_lane16;
    logic [31:0]      w_rspRdata;

    assign w_accept = i_req_valid && r_reqReady;

    // Comparing the whole word-address field against the depth catches both
    // an index past the end and any stray address bits above the index.
    assign w_reqErr = (i_req_size == SZ_ILL)
                   || ((i_req_size == SZ_HALF) && i_req_addr[0])
                   || ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
                   || ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign w_cpuBe = (w_accept && i_req_we && !w_reqErr)
                   ? byteEnables(i_req_size, i_req_addr[1:0]) : 4'b0000;

    // Right-aligned store data is replicated onto every lane so the byte
    // enables alone pick where it lands.
    always_comb begin
        w_storeData = i_req_wdata;
        case (i_req_size)
            SZ_BYTE: w_storeData = {4{i_req_wdata[7:0]}};
            SZ_HALF: w_storeData = {2{i_req_wdata[15:0]}};
            default: w_storeData = i_req_wdata;
        endcase
    end

    // The RAM has a single port: the loader owns it in PROG, the CPU
    // otherwise. CPU accesses only happen when req_ready is high, i.e. RUN.
    always_comb begin
        w_ramEn    = w_accept;
        w_ramBe    = w_cpuBe;
        w_ramAddr  = i_req_addr[IDX_W+1:2];
        w_ramWdata = w_storeData;
        if (r_state == PROG) begin
            w_ramEn    = i_prog_wen;
            w_ramBe    = {4{i_prog_wen}};
            w_ramAddr  = i_prog_addr;
            w_ramWdata = i_prog_wdata;
        end
    end

    mem_bank_be #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .i_clk   (i_clk),
        .i_en    (w_ramEn),
        .i_be    (w_ramBe),
        .i_addr  (w_ramAddr),
        .i_wdata (w_ramWdata),
        .o_rdata (w_ramRdata)
    );

    always_comb begin
        w_newMeta       = '0;
        w_newMeta.valid = w_accept;
        w_newMeta.err   = w_reqErr;
        w_newMeta.we    = i_req_we;
        w_newMeta.size  = i_req_size;
        w_newMeta.uns   = i_req_unsigned;
        w_newMeta.lo    = i_req_addr[1:0];
    end

    // Request bookkeeping shift register; stage 0 lines up with the RAM's
    // registered read data, the last stage is the response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_meta[k] <= '0;
            end
        end else begin
            r_meta[0] <= w_newMeta;
            for (int k = 1; k < RD_LAT; k++) begin
                r_meta[k] <= r_meta[k-1];
            end
        end
    end

    // The RAM supplies the first cycle of latency; the rest is extra data
    // registers that travel alongside the bookkeeping stages.
    generate
        if (RD_LAT == 1) begin : g_noExtra
            assign w_outData = w_ramRdata;
        end else begin : g_extra
            logic [31:0] r_dataPipe [RD_LAT-1];
            always_ff @(posedge i_clk) begin
                r_dataPipe[0] <= w_ramRdata;
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    r_dataPipe[k] <= r_dataPipe[k-1];
                end
            end
            assign w_outData = r_dataPipe[RD_LAT-2];
        end
    endgenerate

    // The final stage retires on the coming edge, so DRAIN may leave once
    // every earlier stage is empty; this bounds DRAIN to RD_LAT cycles.
    always_comb begin
        w_drainDone = 1'b1;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            if (r_meta[k].valid) begin
                w_drainDone = 1'b0;
            end
        end
    end

    assign w_out = r_meta[RD_LAT-1];

    // Lane select and sign/zero extension at the response stage.
    always_comb begin
        w_lane8    = w_outData[{w_out.lo, 3'b000} +: 8];
        w_lane16   = w_out.lo[1] ? w_outData[31:16] : w_outData[15:0];
        w_rspRdata = '0;
        if (w_out.valid && !w_out.err && !w_out.we) begin
            case (w_out.size)
                SZ_BYTE: w_rspRdata = w_out.uns ? {24'b0, w_lane8}
                                                : {{24{w_lane8[7]}}, w_lane8};
                SZ_HALF: w_rspRdata = w_out.uns ? {16'b0, w_lane16}
                                                : {{16{w_lane16[15]}}, w_lane16};
                default: w_rspRdata = w_outData;
            endcase
        end
    end

    assign o_rsp_valid = w_out.valid;
    assign o_rsp_err   = w_out.valid && w_out.err;
    assign o_rsp_rdata = w_rspRdata;

    // Ownership FSM with registered req_ready/cpu_mode. A request accepted
    // alongside prog_start is already in the pipeline and DRAIN waits for it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_reqReady <= 1'b1;
            r_cpuMode  <= 1'b1;
            r_progCnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_prog_start) begin
                        r_state    <= DRAIN;
                        r_reqReady <= 1'b0;
                        r_cpuMode  <= 1'b0;
                        r_progCnt  <= '0;
                    end
                end
                DRAIN: begin
                    if (w_drainDone) begin
                        r_state <= PROG;
                    end
                end
                PROG: begin
                    if (i_prog_wen && (r_progCnt != 16'hFFFF)) begin
                        r_progCnt <= r_progCnt + 16'd1;
                    end
                    if (i_prog_done) begin
                        r_state    <= RUN;
                        r_reqReady <= 1'b1;
                        r_cpuMode  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_reqReady <= 1'b1;
                    r_cpuMode  <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready = r_reqReady;
    assign o_cpu_mode  = r_cpuMode;
    assign o_prog_cnt  = r_progCnt;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl. Two instances share clock and reset:
// "a" uses the default depth with RD_LAT = 1, "b" uses 64 words with
// RD_LAT = 3 for the pipelining, programming-mode and boundary cases.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int A_IDX = 14;
    localparam int B_IDX = 6;

    logic clk = 1'b0;
    logic rst;

    logic             aReqValid, aReqReady, aReqWe, aReqUns;
    logic [1:0]       aReqSize;
    logic [31:0]      aReqAddr, aReqWdata, aRspRdata, aProgWdata;
    logic             aRspValid, aRspErr, aProgStart, aProgWen, aProgDone, aCpuMode;
    logic [A_IDX-1:0] aProgAddr;
    logic [15:0]      aProgCnt;

    logic             bReqValid, bReqReady, bReqWe, bReqUns;
    logic [1:0]       bReqSize;
    logic [31:0]      bReqAddr, bReqWdata, bRspRdata, bProgWdata;
    logic             bRspValid, bRspErr, bProgStart, bProgWen, bProgDone, bCpuMode;
    logic [B_IDX-1:0] bProgAddr;
    logic [15:0]      bProgCnt;

    int compared   = 0;
    int mismatched = 0;

    int          lat;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(16384), .RD_LAT(1)) dutA (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(aReqValid), .o_req_ready(aReqReady), .i_req_we(aReqWe),
        .i_req_size(aReqSize), .i_req_unsigned(aReqUns), .i_req_addr(aReqAddr),
        .i_req_wdata(aReqWdata), .o_rsp_valid(aRspValid), .o_rsp_rdata(aRspRdata),
        .o_rsp_err(aRspErr), .i_prog_start(aProgStart), .i_prog_wen(aProgWen),
        .i_prog_addr(aProgAddr), .i_prog_wdata(aProgWdata), .i_prog_done(aProgDone),
        .o_cpu_mode(aCpuMode), .o_prog_cnt(aProgCnt)
    );

    data_mem_ctrl #(.DEPTH_WORDS(64), .RD_LAT(3)) dutB (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(bReqValid), .o_req_ready(bReqReady), .i_req_we(bReqWe),
        .i_req_size(bReqSize), .i_req_unsigned(bReqUns), .i_req_addr(bReqAddr),
        .i_req_wdata(bReqWdata), .o_rsp_valid(bRspValid), .o_rsp_rdata(bRspRdata),
        .o_rsp_err(bRspErr), .i_prog_start(bProgStart), .i_prog_wen(bProgWen),
        .i_prog_addr(bProgAddr), .i_prog_wdata(bProgWdata), .i_prog_done(bProgDone),
        .o_cpu_mode(bCpuMode), .o_prog_cnt(bProgCnt)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Presents one request on the selected instance (0 = a, 1 = b).
    task automatic applyStimulus(input bit sel, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (sel) begin
            bReqValid = 1'b1; bReqWe = we; bReqSize = size; bReqUns = uns;
            bReqAddr = addr; bReqWdata = wdata;
        end else begin
            aReqValid = 1'b1; aReqWe = we; aReqSize = size; aReqUns = uns;
            aReqAddr = addr; aReqWdata = wdata;
        end
    endtask

    task automatic idleReq(input bit sel);
        if (sel) begin
            bReqValid = 1'b0; bReqWe = 1'b0; bReqSize = SZ_BYTE; bReqUns = 1'b0;
            bReqAddr = '0; bReqWdata = '0;
        end else begin
            aReqValid = 1'b0; aReqWe = 1'b0; aReqSize = SZ_BYTE; aReqUns = 1'b0;
            aReqAddr = '0; aReqWdata = '0;
        end
    endtask

    // Called at a negedge: issues one request, then counts cycles until the
    // response shows up (bounded), returning the latency and response.
    task automatic singleReq(input bit sel, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] wdata, output int latency,
                             output logic [31:0] rspData, output logic rspErr);
        logic v;
        applyStimulus(sel, we, size, uns, addr, wdata);
        @(negedge clk);
        idleReq(sel);
        latency = 1;
        v = sel ? bRspValid : aRspValid;
        while (!v && latency < 8) begin
            @(negedge clk);
            latency++;
            v = sel ? bRspValid : aRspValid;
        end
        rspData = sel ? bRspRdata : aRspRdata;
        rspErr  = sel ? bRspErr : aRspErr;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        idleReq(1'b0);
        idleReq(1'b1);
        aProgStart = 1'b0; aProgWen = 1'b0; aProgAddr = '0; aProgWdata = '0; aProgDone = 1'b0;
        bProgStart = 1'b0; bProgWen = 1'b0; bProgAddr = '0; bProgWdata = '0; bProgDone = 1'b0;

        #1;
        checkOutput("rst reqReady", 32'(aReqReady), 32'd1);
        checkOutput("rst cpuMode",  32'(aCpuMode),  32'd1);
        checkOutput("rst rspValid", 32'(aRspValid), 32'd0);
        checkOutput("rst rspRdata", aRspRdata,      32'd0);
        checkOutput("rst rspErr",   32'(aRspErr),   32'd0);
        checkOutput("rst progCnt",  32'(aProgCnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- RD_LAT = 1 ----------------
        singleReq(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, lat, rdata, err);
        checkOutput("sw10 lat", 32'(lat), 32'd1);
        checkOutput("sw10 rdata", rdata, 32'd0);
        checkOutput("sw10 err", 32'(err), 32'd0);
        singleReq(0, 0, SZ_BYTE, 0, 32'h13, 32'h0, lat, rdata, err);
        checkOutput("lb13", rdata, 32'hFFFFFFDE);
        singleReq(0, 0, SZ_BYTE, 1, 32'h13, 32'h0, lat, rdata, err);
        checkOutput("lbu13", rdata, 32'h000000DE);
        singleReq(0, 0, SZ_HALF, 0, 32'h12, 32'h0, lat, rdata, err);
        checkOutput("lh12", rdata, 32'hFFFFDEAD);

        singleReq(0, 1, SZ_BYTE, 0, 32'h11, 32'h0000005A, lat, rdata, err);
        checkOutput("sb11 err", 32'(err), 32'd0);
        singleReq(0, 0, SZ_WORD, 0, 32'h10, 32'h0, lat, rdata, err);
        checkOutput("lw10 lat", 32'(lat), 32'd1);
        checkOutput("lw10", rdata, 32'hDEAD5AEF);
        @(negedge clk);
        checkOutput("lw10 single pulse", 32'(aRspValid), 32'd0);
        singleReq(0, 0, SZ_HALF, 1, 32'h10, 32'h0, lat, rdata, err);
        checkOutput("lhu10", rdata, 32'h00005AEF);
        singleReq(0, 0, SZ_HALF, 1, 32'h12, 32'h0, lat, rdata, err);
        checkOutput("lhu12", rdata, 32'h0000DEAD);

        singleReq(0, 0, SZ_WORD, 0, 32'h06, 32'h0, lat, rdata, err);
        checkOutput("lw06 err", 32'(err), 32'd1);
        checkOutput("lw06 rdata", rdata, 32'd0);
        singleReq(0, 1, SZ_WORD, 0, 32'h20, 32'h11223344, lat, rdata, err);
        singleReq(0, 1, SZ_HALF, 0, 32'h21, 32'h0000BEEF, lat, rdata, err);
        checkOutput("sh21 err", 32'(err), 32'd1);
        singleReq(0, 1, SZ_ILL, 0, 32'h20, 32'hFFFFFFFF, lat, rdata, err);
        checkOutput("size11 err", 32'(err), 32'd1);
        checkOutput("size11 rdata", rdata, 32'd0);
        singleReq(0, 0, SZ_WORD, 0, 32'h20, 32'h0, lat, rdata, err);
        checkOutput("lw20 unchanged", rdata, 32'h11223344);
        singleReq(0, 1, SZ_HALF, 0, 32'h22, 32'h00007777, lat, rdata, err);
        singleReq(0, 0, SZ_WORD, 0, 32'h20, 32'h0, lat, rdata, err);
        checkOutput("lw20 after sh22", rdata, 32'h77773344);
        singleReq(0, 0, SZ_WORD, 0, 32'h0001_0000, 32'h0, lat, rdata, err);
        checkOutput("lw range err", 32'(err), 32'd1);

        // Store then load of the same word on consecutive cycles.
        applyStimulus(0, 1, SZ_WORD, 0, 32'h30, 32'hA5A50F0F);
        @(negedge clk);
        checkOutput("b2b store rsp", 32'(aRspValid), 32'd1);
        applyStimulus(0, 0, SZ_WORD, 0, 32'h30, 32'h0);
        @(negedge clk);
        idleReq(0);
        checkOutput("b2b load valid", 32'(aRspValid), 32'd1);
        checkOutput("b2b load data", aRspRdata, 32'hA5A50F0F);
        @(negedge clk);

        // ---------------- RD_LAT = 3 ----------------
        applyStimulus(1, 1, SZ_WORD, 0, 32'h0, 32'h11110000);
        @(negedge clk);
        applyStimulus(1, 1, SZ_WORD, 0, 32'h4, 32'h22220004);
        @(negedge clk);
        applyStimulus(1, 1, SZ_WORD, 0, 32'h8, 32'h33330008);
        @(negedge clk);
        idleReq(1);
        repeat (4) @(negedge clk);

        applyStimulus(1, 0, SZ_WORD, 0, 32'h0, 32'h0);
        @(negedge clk);
        applyStimulus(1, 0, SZ_WORD, 0, 32'h4, 32'h0);
        @(negedge clk);
        applyStimulus(1, 0, SZ_WORD, 0, 32'h8, 32'h0);
        bProgStart = 1'b1;
        bProgWen = 1'b1; bProgAddr = 6'd4; bProgWdata = 32'h12345678;
        @(negedge clk);
        idleReq(1);
        bProgStart = 1'b0;
        checkOutput("drain rsp0 valid", 32'(bRspValid), 32'd1);
        checkOutput("drain rsp0 data", bRspRdata, 32'h11110000);
        checkOutput("drain cpuMode", 32'(bCpuMode), 32'd0);
        checkOutput("drain reqReady0", 32'(bReqReady), 32'd0);
        @(negedge clk);
        checkOutput("drain rsp1 data", bRspRdata, 32'h22220004);
        checkOutput("drain reqReady1", 32'(bReqReady), 32'd0);
        @(negedge clk);
        checkOutput("drain rsp2 valid", 32'(bRspValid), 32'd1);
        checkOutput("drain rsp2 data", bRspRdata, 32'h33330008);
        checkOutput("drain progCnt", 32'(bProgCnt), 32'd0);
        @(negedge clk);
        checkOutput("prog entry rspValid", 32'(bRspValid), 32'd0);
        checkOutput("prog entry progCnt", 32'(bProgCnt), 32'd0);
        checkOutput("prog reqReady", 32'(bReqReady), 32'd0);
        @(negedge clk);
        checkOutput("prog first write", 32'(bProgCnt), 32'd1);
        bProgAddr = 6'd5; bProgWdata = 32'hCAFEF00D; bProgDone = 1'b1;
        @(negedge clk);
        bProgWen = 1'b0; bProgDone = 1'b0;
        checkOutput("prog done cnt", 32'(bProgCnt), 32'd2);
        checkOutput("prog done cpuMode", 32'(bCpuMode), 32'd1);
        checkOutput("prog done reqReady", 32'(bReqReady), 32'd1);
        singleReq(1, 0, SZ_WORD, 0, 32'h14, 32'h0, lat, rdata, err);
        checkOutput("lw14 lat", 32'(lat), 32'd3);
        checkOutput("lw14", rdata, 32'hCAFEF00D);
        singleReq(1, 0, SZ_WORD, 0, 32'h10, 32'h0, lat, rdata, err);
        checkOutput("lw10 prog", rdata, 32'h12345678);

        // Boundary of a 64-word bank.
        singleReq(1, 1, SZ_WORD, 0, 32'hFC, 32'h600DF00D, lat, rdata, err);
        checkOutput("swFC err", 32'(err), 32'd0);
        singleReq(1, 0, SZ_WORD, 0, 32'hFC, 32'h0, lat, rdata, err);
        checkOutput("lwFC", rdata, 32'h600DF00D);
        singleReq(1, 0, SZ_WORD, 0, 32'h100, 32'h0, lat, rdata, err);
        checkOutput("lw100 err", 32'(err), 32'd1);
        checkOutput("lw100 rdata", rdata, 32'd0);
        singleReq(1, 0, SZ_WORD, 0, 32'h8000_0010, 32'h0, lat, rdata, err);
        checkOutput("lw upper err", 32'(err), 32'd1);

        // Reset in the middle of programming.
        bProgStart = 1'b1;
        @(negedge clk);
        bProgStart = 1'b0;
        bProgWen = 1'b1; bProgAddr = 6'd6; bProgWdata = 32'h0BADCAFE;
        for (int i = 0; i < 10 && bProgCnt != 16'd1; i++) begin
            @(negedge clk);
        end
        bProgWen = 1'b0;
        checkOutput("rstPrep cnt", 32'(bProgCnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRst reqReady", 32'(bReqReady), 32'd1);
        checkOutput("midRst cpuMode",  32'(bCpuMode),  32'd1);
        checkOutput("midRst rspValid", 32'(bRspValid), 32'd0);
        checkOutput("midRst rspRdata", bRspRdata,      32'd0);
        checkOutput("midRst rspErr",   32'(bRspErr),   32'd0);
        checkOutput("midRst progCnt",  32'(bProgCnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        singleReq(1, 0, SZ_WORD, 0, 32'h18, 32'h0, lat, rdata, err);
        checkOutput("lw18 retained", rdata, 32'h0BADCAFE);
        singleReq(1, 0, SZ_WORD, 0, 32'h14, 32'h0, lat, rdata, err);
        checkOutput("lw14 retained", rdata, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
